// File: rtl/hpdcache_sram_ecc_rmw_ctrl.sv
// hpdcache_sram_ecc_rmw_ctrl: turns partial byte-enable writes into read-merge-write on a 1RW ECC SRAM
module hpdcache_sram_ecc_rmw_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 64,
    parameter int NDATA     = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [ADDR_SIZE-1:0]            req_addr_i,
    input  logic [NDATA*DATA_SIZE-1:0]      req_wdata_i,
    input  logic [NDATA*DATA_SIZE/8-1:0]    req_wbyteenable_i,
    output logic                            rsp_valid_o,
    output logic                            rsp_we_o,
    output logic [NDATA*DATA_SIZE-1:0]      rsp_rdata_o,
    output logic [NDATA-1:0]                rsp_err_cor_o,
    output logic [NDATA-1:0]                rsp_err_unc_o,
    output logic                            sram_cs_o,
    output logic                            sram_we_o,
    output logic [ADDR_SIZE-1:0]            sram_addr_o,
    output logic [NDATA*DATA_SIZE-1:0]      sram_wdata_o,
    output logic [NDATA*DATA_SIZE/8-1:0]    sram_wbyteenable_o,
    input  logic [NDATA*DATA_SIZE-1:0]      sram_rdata_i,
    input  logic [NDATA-1:0]                sram_err_cor_i,
    input  logic [NDATA-1:0]                sram_err_unc_i,
    output logic [CNT_WIDTH-1:0]            cor_cnt_o
);
    localparam int BPW = DATA_SIZE / 8;
    localparam int NB  = NDATA * BPW;
    localparam int W   = NDATA * DATA_SIZE;

    typedef enum logic [1:0] {IDLE, RD_DATA, RMW_MERGE, WR_ACK} state_t;

    state_t                 state_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [W-1:0]           wdata_q;
    logic [NB-1:0]          be_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [NDATA-1:0]       req_part, q_part, q_used;
    logic                   req_is_part, unc_hit, run;
    logic [W-1:0]           merged;
    logic [NB-1:0]          merge_be;

    // word classification of the incoming and the held request, plus the merged row
    always_comb begin
        req_part = '0;
        q_part   = '0;
        q_used   = '0;
        merged   = '0;
        merge_be = '0;
        for (int i = 0; i < NDATA; i++) begin
            req_part[i] = |req_wbyteenable_i[i*BPW +: BPW] && !(&req_wbyteenable_i[i*BPW +: BPW]);
            q_part[i]   = |be_q[i*BPW +: BPW] && !(&be_q[i*BPW +: BPW]);
            q_used[i]   = |be_q[i*BPW +: BPW];
        end
        for (int b = 0; b < NB; b++) begin
            merged[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : sram_rdata_i[b*8 +: 8];
            merge_be[b]      = q_used[b/BPW];
        end
        req_is_part = req_we_i && |req_part;
        unc_hit     = |(sram_err_unc_i & q_part);
    end

    assign run         = !rst_i;
    assign req_ready_o = run && state_q == IDLE;

    // SRAM command: direct access from IDLE, merged write-back from RMW_MERGE
    always_comb begin
        sram_cs_o          = 1'b0;
        sram_we_o          = 1'b0;
        sram_addr_o        = '0;
        sram_wdata_o       = '0;
        sram_wbyteenable_o = '0;
        if (run && state_q == IDLE && req_valid_i) begin
            sram_cs_o          = 1'b1;
            sram_we_o          = req_we_i && !req_is_part;
            sram_addr_o        = req_addr_i;
            sram_wdata_o       = req_wdata_i;
            sram_wbyteenable_o = (req_we_i && !req_is_part) ? req_wbyteenable_i : '0;
        end else if (run && state_q == RMW_MERGE && !unc_hit) begin
            sram_cs_o          = 1'b1;
            sram_we_o          = 1'b1;
            sram_addr_o        = addr_q;
            sram_wdata_o       = merged;
            sram_wbyteenable_o = merge_be;
        end
    end

    // completion: error flags only reach the requester for words it actually asked to merge
    always_comb begin
        rsp_valid_o   = run && state_q != IDLE;
        rsp_we_o      = run && (state_q == RMW_MERGE || state_q == WR_ACK);
        rsp_rdata_o   = (run && state_q == RD_DATA) ? sram_rdata_i : '0;
        rsp_err_cor_o = !run ? '0 : state_q == RD_DATA ? sram_err_cor_i :
                        state_q == RMW_MERGE ? (sram_err_cor_i & q_part) : '0;
        rsp_err_unc_o = !run ? '0 : state_q == RD_DATA ? sram_err_unc_i :
                        state_q == RMW_MERGE ? (sram_err_unc_i & q_part) : '0;
    end

    assign cor_cnt_o = cnt_q;

    // FSM, request capture and saturating corrected-error counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= (state_q == IDLE && req_valid_i) ?
                       (!req_we_i ? RD_DATA : req_is_part ? RMW_MERGE : WR_ACK) : IDLE;
            if (state_q == IDLE && req_valid_i) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_wbyteenable_i;
            end
            if (rsp_valid_o && |rsp_err_cor_o && !(&cnt_q))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end
endmodule
